// File: rtl/tcon_pkg.sv
// Shared defaults and channel-select encoding for the two-channel demux.
package tcon_pkg;
  localparam int DATA_W_DEF = 8;
  localparam int DEPTH_DEF  = 2;

  localparam logic SEL_A = 1'b1;
  localparam logic SEL_B = 1'b0;
endpackage

// File: rtl/tcon_fifo.sv
// Synchronous FIFO with registered storage, wrap-around pointers and an occupancy count.
module tcon_fifo
  import tcon_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = DEPTH_DEF
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push_i,
  input  logic [DATA_W-1:0]        data_i,
  input  logic                     pop_i,
  output logic [DATA_W-1:0]        data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   level_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_q, wr_d, rd_q, rd_d;
  logic [LW-1:0]     level_q, level_d;
  logic              do_push, do_pop;

  assign full_o  = (level_q == LW'(DEPTH));
  assign empty_o = (level_q == '0);
  assign level_o = level_q;
  assign data_o  = mem_q[rd_q];

  // Pop of an empty FIFO and push into a full one are both dropped here.
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_comb begin
    wr_d    = wr_q;
    rd_d    = rd_q;
    level_d = level_q;
    if (do_push) wr_d = wr_q + AW'(1);
    if (do_pop)  rd_d = rd_q + AW'(1);
    if (do_push && !do_pop)      level_d = level_q + LW'(1);
    else if (do_pop && !do_push) level_d = level_q - LW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q    <= '0;
      rd_q    <= '0;
      level_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      level_q <= level_d;
      if (do_push) mem_q[wr_q] <= data_i;
    end
  end
endmodule

// File: rtl/tcon_demux.sv
// Routes a shared input stream to one of two independent channel FIFOs by in_sel.
module tcon_demux
  import tcon_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = DEPTH_DEF
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [DATA_W-1:0]      in_data,
  input  logic                   in_sel,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic [DATA_W-1:0]      a_data,
  output logic                   a_valid,
  input  logic                   a_ready,
  output logic [DATA_W-1:0]      b_data,
  output logic                   b_valid,
  input  logic                   b_ready,
  output logic [$clog2(DEPTH):0] a_level,
  output logic [$clog2(DEPTH):0] b_level
);
  logic a_full, a_empty, b_full, b_empty;
  logic push_a, push_b;

  // Ready looks only at the selected FIFO's full flag, never at the consumer readies.
  assign in_ready = (in_sel == SEL_A) ? !a_full : !b_full;
  assign push_a   = in_valid && in_ready && (in_sel == SEL_A);
  assign push_b   = in_valid && in_ready && (in_sel == SEL_B);
  assign a_valid  = !a_empty;
  assign b_valid  = !b_empty;

  tcon_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo_a (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push_a),
    .data_i  (in_data),
    .pop_i   (a_ready),
    .data_o  (a_data),
    .full_o  (a_full),
    .empty_o (a_empty),
    .level_o (a_level)
  );

  tcon_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo_b (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push_b),
    .data_i  (in_data),
    .pop_i   (b_ready),
    .data_o  (b_data),
    .full_o  (b_full),
    .empty_o (b_empty),
    .level_o (b_level)
  );
endmodule

// File: tb/tb_tcon_demux.sv
// Bench for tcon_demux: directed scenarios plus random traffic against per-channel byte queues.
module tb_tcon_demux;
  localparam int DATA_W = 8;
  localparam int DEPTH  = 2;
  localparam int LW     = $clog2(DEPTH) + 1;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [DATA_W-1:0] in_data;
  logic              in_sel, in_valid, in_ready;
  logic [DATA_W-1:0] a_data, b_data;
  logic              a_valid, a_ready, b_valid, b_ready;
  logic [LW-1:0]     a_level, b_level;

  int checks   = 0;
  int failures = 0;
  int pushed   = 0;

  logic [DATA_W-1:0] qa[$];
  logic [DATA_W-1:0] qb[$];

  always #5 clk = ~clk;

  tcon_demux #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_data(in_data), .in_sel(in_sel), .in_valid(in_valid), .in_ready(in_ready),
    .a_data(a_data), .a_valid(a_valid), .a_ready(a_ready),
    .b_data(b_data), .b_valid(b_valid), .b_ready(b_ready),
    .a_level(a_level), .b_level(b_level)
  );

  // Apply inputs away from the rising edge.
  task automatic drive(input logic v, input logic s, input logic [DATA_W-1:0] d,
                       input logic ar, input logic br);
    @(negedge clk);
    in_valid = v; in_sel = s; in_data = d; a_ready = ar; b_ready = br;
    #1;
  endtask

  // Advance the reference queues by the transfers implied by the current inputs, then clock.
  task automatic tick();
    logic [DATA_W-1:0] tmp;
    bit room;
    room = in_sel ? (qa.size() < DEPTH) : (qb.size() < DEPTH);
    if (a_ready && qa.size() > 0) tmp = qa.pop_front();
    if (b_ready && qb.size() > 0) tmp = qb.pop_front();
    if (in_valid && room) begin
      if (in_sel) qa.push_back(in_data); else qb.push_back(in_data);
      pushed++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    in_valid = 1'b0; in_sel = 1'b1; in_data = '0; a_ready = 1'b0; b_ready = 1'b0;
    #12;
    checks++; if (a_valid !== 1'b0 || b_valid !== 1'b0) begin
      failures++; $display("FAIL reset_valid a=%b b=%b expected 0 0", a_valid, b_valid); end
    checks++; if (a_level !== '0 || b_level !== '0) begin
      failures++; $display("FAIL reset_level a=%0d b=%0d expected 0 0", a_level, b_level); end
    checks++; if (a_data !== '0 || b_data !== '0) begin
      failures++; $display("FAIL reset_data a=%h b=%h expected 00 00", a_data, b_data); end
    checks++; if (in_ready !== 1'b1) begin
      failures++; $display("FAIL reset_ready_a got=%b expected 1", in_ready); end
    in_sel = 1'b0; #1;
    checks++; if (in_ready !== 1'b1) begin
      failures++; $display("FAIL reset_ready_b got=%b expected 1", in_ready); end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin
      failures++; $display("FAIL post_reset_ready got=%b expected 1", in_ready); end
  endtask

  task automatic test_first_push();
    drive(1'b1, 1'b1, 8'h5A, 1'b0, 1'b0);
    tick();
    checks++; if (a_valid !== 1'b1 || a_data !== 8'h5A || a_level !== LW'(1) || b_valid !== 1'b0) begin
      failures++;
      $display("FAIL first_push a_valid=%b a_data=%h a_level=%0d b_valid=%b expected 1 5a 1 0",
               a_valid, a_data, a_level, b_valid);
    end
    drive(1'b0, 1'b1, 8'h00, 1'b1, 1'b0);
    tick();
    checks++; if (a_valid !== 1'b0 || a_level !== '0) begin
      failures++; $display("FAIL first_pop a_valid=%b a_level=%0d expected 0 0", a_valid, a_level); end
  endtask

  task automatic test_fill_a();
    drive(1'b1, 1'b1, 8'h11, 1'b0, 1'b0); tick();
    drive(1'b1, 1'b1, 8'h22, 1'b0, 1'b0); tick();
    checks++; if (a_level !== LW'(2)) begin
      failures++; $display("FAIL fill_a_level got=%0d expected 2", a_level); end
    drive(1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
    checks++; if (in_ready !== 1'b0) begin
      failures++; $display("FAIL full_a_ready got=%b expected 0", in_ready); end
    drive(1'b1, 1'b0, 8'h33, 1'b0, 1'b0);
    checks++; if (in_ready !== 1'b1) begin
      failures++; $display("FAIL b_ready_while_a_full got=%b expected 1", in_ready); end
    tick();
    checks++; if (b_valid !== 1'b1 || b_data !== 8'h33 || b_level !== LW'(1)) begin
      failures++; $display("FAIL push_b valid=%b data=%h level=%0d expected 1 33 1", b_valid, b_data, b_level); end
    checks++; if (a_level !== LW'(2) || a_data !== 8'h11) begin
      failures++; $display("FAIL a_untouched level=%0d data=%h expected 2 11", a_level, a_data); end
  endtask

  task automatic test_full_pop_no_push();
    drive(1'b1, 1'b1, 8'h99, 1'b1, 1'b0);
    checks++; if (in_ready !== 1'b0) begin
      failures++; $display("FAIL full_pop_ready got=%b expected 0", in_ready); end
    tick();
    checks++; if (a_level !== LW'(1) || a_data !== 8'h22) begin
      failures++; $display("FAIL full_pop_state level=%0d data=%h expected 1 22", a_level, a_data); end
    drive(1'b0, 1'b1, 8'h00, 1'b0, 1'b1);
    checks++; if (in_ready !== 1'b1) begin
      failures++; $display("FAIL after_pop_ready got=%b expected 1", in_ready); end
    tick();
    checks++; if (b_valid !== 1'b0 || b_level !== '0) begin
      failures++; $display("FAIL drain_b valid=%b level=%0d expected 0 0", b_valid, b_level); end
  endtask

  task automatic test_push_pop_same_cycle();
    drive(1'b1, 1'b1, 8'h44, 1'b1, 1'b0);
    tick();
    checks++; if (a_level !== LW'(1) || a_data !== 8'h44 || a_valid !== 1'b1) begin
      failures++; $display("FAIL push_pop level=%0d data=%h valid=%b expected 1 44 1", a_level, a_data, a_valid); end
    drive(1'b0, 1'b1, 8'h00, 1'b1, 1'b0);
    tick();
    checks++; if (a_valid !== 1'b0 || a_level !== '0) begin
      failures++; $display("FAIL push_pop_drain valid=%b level=%0d expected 0 0", a_valid, a_level); end
  endtask

  task automatic test_random(input int n_bytes);
    int start, cycles;
    bit exp_ready;
    start  = pushed;
    cycles = 0;
    while (pushed - start < n_bytes && cycles < 20000) begin
      drive(($urandom_range(0, 3) != 0), $urandom_range(0, 1), DATA_W'($urandom),
            ($urandom_range(0, 4) < 3), ($urandom_range(0, 4) < 3));
      exp_ready = in_sel ? (qa.size() < DEPTH) : (qb.size() < DEPTH);
      checks++; if (in_ready !== exp_ready) begin
        failures++; $display("FAIL rnd_ready cyc=%0d got=%b expected %b", cycles, in_ready, exp_ready); end
      checks++; if (a_valid !== (qa.size() > 0) || a_level !== LW'(qa.size())) begin
        failures++; $display("FAIL rnd_a_state cyc=%0d valid=%b level=%0d expected level %0d",
                             cycles, a_valid, a_level, qa.size()); end
      checks++; if (b_valid !== (qb.size() > 0) || b_level !== LW'(qb.size())) begin
        failures++; $display("FAIL rnd_b_state cyc=%0d valid=%b level=%0d expected level %0d",
                             cycles, b_valid, b_level, qb.size()); end
      if (qa.size() > 0) begin
        checks++; if (a_data !== qa[0]) begin
          failures++; $display("FAIL rnd_a_data cyc=%0d got=%h expected %h", cycles, a_data, qa[0]); end
      end
      if (qb.size() > 0) begin
        checks++; if (b_data !== qb[0]) begin
          failures++; $display("FAIL rnd_b_data cyc=%0d got=%h expected %h", cycles, b_data, qb[0]); end
      end
      tick();
      cycles++;
    end
    checks++; if (pushed - start < n_bytes) begin
      failures++; $display("FAIL rnd_timeout pushed=%0d expected %0d", pushed - start, n_bytes); end
  endtask

  task automatic test_mid_reset();
    drive(1'b1, 1'b1, 8'hA1, 1'b0, 1'b0); tick();
    drive(1'b1, 1'b1, 8'hA2, 1'b0, 1'b0); tick();
    drive(1'b1, 1'b0, 8'hB1, 1'b0, 1'b0); tick();
    drive(1'b1, 1'b0, 8'hB2, 1'b0, 1'b0); tick();
    drive(1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
    checks++; if (a_level !== LW'(2) || b_level !== LW'(2) || in_ready !== 1'b0) begin
      failures++; $display("FAIL both_full a=%0d b=%0d ready=%b expected 2 2 0", a_level, b_level, in_ready); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (a_valid !== 1'b0 || b_valid !== 1'b0 || a_level !== '0 || b_level !== '0) begin
      failures++; $display("FAIL async_clear valid=%b%b level=%0d/%0d expected 00 0/0",
                           a_valid, b_valid, a_level, b_level); end
    checks++; if (a_data !== '0 || b_data !== '0 || in_ready !== 1'b1) begin
      failures++; $display("FAIL async_clear_data a=%h b=%h ready=%b expected 00 00 1", a_data, b_data, in_ready); end
    qa.delete();
    qb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b1, 1'b0, 8'hC3, 1'b0, 1'b0);
    tick();
    checks++; if (b_valid !== 1'b1 || b_data !== 8'hC3 || b_level !== LW'(1) || a_valid !== 1'b0) begin
      failures++; $display("FAIL post_reset_push b_valid=%b b_data=%h b_level=%0d a_valid=%b expected 1 c3 1 0",
                           b_valid, b_data, b_level, a_valid); end
    test_random(100);
  endtask

  initial begin
    test_reset();
    test_first_push();
    test_fill_a();
    test_full_pop_no_push();
    test_push_pop_same_cycle();
    test_random(1000);
    test_mid_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
